cl_song_sequencer: RTL and testbench
====================================

# cl_song_sequencer

Playback controller for the song timer. Converts debounced start/pause/abort button pulses into the timer's `pause` and `reset` controls, and runs a pre-song countdown. It detects end-of-song by comparing the timer's 10 ms count against a latched song length. It sits between the button/debounce front end and the song timer, and publishes the game state to the display and scoring logic.

## Interface
- `CYCLES_PER_SEC`, default 100_000_000: clk cycles per countdown second.
- `COUNTDOWN_SEC`, default 3: countdown length in seconds; legal range 1..9.
- `TIME_W`, default 16: width of the song time and length values, in 10 ms units.

Ports:
- `clk`  in  1: 100 MHz system clock.
- `reset`  in  1: synchronous, active-high.
- `start_p`  in  1: one-cycle start/restart request.
- `pause_p`  in  1: one-cycle pause/resume toggle request.
- `abort_p`  in  1: one-cycle abort request.
- `song_length`  in  TIME_W: song duration in 10 ms units; sampled on an accepted start.
- `song_time`  in  TIME_W: current count from the song timer.
- `timer_pause`  out  1: drives the timer's `pause` input.
- `timer_reset`  out  1: drives the timer's `reset` input.
- `state`  out  3: current state code.
- `countdown_digit`  out  4: seconds remaining; nonzero only in COUNTDOWN.
- `song_done`  out  1: one-cycle pulse on entry to FINISHED.

## Operation
- States: IDLE=0, COUNTDOWN=1, PLAYING=2, PAUSED=3, FINISHED=4.
- Request priority each cycle: abort > start > pause. Only one request acts per cycle.
- IDLE:
  - `start_p` -> COUNTDOWN.
  - Latch `len_q <= song_length`.
  - Load the second counter and set `countdown_digit = COUNTDOWN_SEC`.
- COUNTDOWN:
  - A cycle prescaler counts 0..CYCLES_PER_SEC-1. At each wrap, `countdown_digit` decrements.
  - At the wrap where the digit would reach 0, go to PLAYING, or to FINISHED if `len_q == 0`.
  - `pause_p` is ignored. `start_p` reloads the countdown and relatches `len_q`.
- PLAYING:
  - `pause_p` -> PAUSED.
  - `song_time >= len_q` -> FINISHED.
  - `start_p` -> COUNTDOWN (restart from zero).
- PAUSED:
  - `pause_p` -> PLAYING.
  - `start_p` -> COUNTDOWN.
  - The end-of-song comparison is not evaluated.
- FINISHED: `start_p` -> COUNTDOWN.
- Any state except IDLE: `abort_p` -> IDLE.
- `timer_pause` = 1 in every state except PLAYING.
- `timer_reset` = 1 for exactly one cycle on every entry to COUNTDOWN and on every entry to IDLE.
- The comparison is unsigned, full TIME_W width. `song_time` that wraps past `len_q` is not handled; `len_q` must be < 2^TIME_W − 1.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE
  - timer_pause = 1
  - timer_reset = 1 (one cycle, then 0)
  - countdown_digit = 0
  - song_done = 0
  - len_q = 0
  - prescaler = 0
- A request sampled at cycle N: the new state and its outputs are visible at N+1.
- Countdown duration, from the first COUNTDOWN cycle to the first PLAYING cycle: exactly COUNTDOWN_SEC·CYCLES_PER_SEC cycles.
- `timer_pause` falls in the same cycle that `state` becomes PLAYING.
- End detection: `song_time >= len_q` sampled at cycle N gives FINISHED, `song_done=1` and `timer_pause=1` at N+1. `song_done` is 0 at N+2.
- Pause/resume: `timer_pause` toggles one cycle after `pause_p`. The timer's internal sub-10 ms count is preserved, because the timer holds it while paused.
- Reset mid-operation overrides all requests and returns every output to its reset value at the next cycle.

## Structure
- Shared package `cl_game_pkg` holds:
  - state encoding constants (`ST_IDLE`..`ST_FINISHED`);
  - `TIME_W` default;
  - `CLK_HZ = 100_000_000`.
- Sub-module `cl_sec_prescaler`:
  - parameter CYCLES_PER_SEC;
  - inputs `clk`, `reset`, `clear`, `en`;
  - output `sec_tick`, a one-cycle pulse at each wrap.
- The main block holds the FSM, `len_q`, the digit counter and the output registers.

## Test plan
All scenarios use CYCLES_PER_SEC=10, COUNTDOWN_SEC=3, TIME_W=16.
- Reset -> state=0, timer_pause=1, timer_reset=1 for one cycle, digit=0.
- start_p with song_length=5 -> COUNTDOWN next cycle, timer_reset pulse, digit 3→2→1 at +10/+20 cycles, PLAYING at +30, timer_pause=0.
- PLAYING, drive song_time 4 then 5 -> FINISHED one cycle after 5, song_done single pulse, timer_pause=1.
- PLAYING, pause_p -> PAUSED, timer_pause=1; song_time=9 while paused -> stays PAUSED; pause_p -> PLAYING, then FINISHED next cycle.
- Same-cycle abort_p+start_p+pause_p in PLAYING -> IDLE, timer_reset pulse; start with song_length=0 -> FINISHED after 30 countdown cycles, with no PLAYING cycle.
- Reset asserted in mid-COUNTDOWN at digit=2 -> IDLE, digit=0; no PLAYING without a new start_p.

Source files
------------

// File: rtl/cl_game_pkg.sv
// Shared game definitions: state encoding and timing defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cl_game_pkg;

  localparam int CLK_HZ         = 100_000_000;
  localparam int TIME_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_FINISHED  = 3'd4
  } state_t;

endpackage

// File: rtl/cl_sec_prescaler.sv
// Cycle prescaler producing a one-cycle tick every CYCLES_PER_SEC enabled cycles.
// Latency: sec_tick is combinational from the count register (asserted on the last cycle of each second).
// Backpressure: none; clear restarts the second, en freezes the count when low.
module cl_sec_prescaler
  import cl_game_pkg::*;
#(
  parameter int CYCLES_PER_SEC = CLK_HZ
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic sec_tick
);

  localparam int CW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_SEC - 1);

  logic [CW-1:0] cnt_q;

  assign sec_tick = en && (cnt_q == LAST);

  // Count enabled cycles 0..CYCLES_PER_SEC-1; clear wins so a fresh second starts at zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= sec_tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cl_song_sequencer.sv
// Song playback controller: button pulses -> timer pause/reset, countdown, end-of-song detect.
// Latency: one cycle from a sampled request or end condition to the new state and outputs.
// Backpressure: none; requests are single-cycle pulses and a request not honoured that cycle is dropped.
module cl_song_sequencer
  import cl_game_pkg::*;
#(
  parameter int CYCLES_PER_SEC = CLK_HZ,
  parameter int COUNTDOWN_SEC  = 3,
  parameter int TIME_W         = TIME_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_p,
  input  logic              pause_p,
  input  logic              abort_p,
  input  logic [TIME_W-1:0] song_length,
  input  logic [TIME_W-1:0] song_time,
  output logic              timer_pause,
  output logic              timer_reset,
  output logic [2:0]        state,
  output logic [3:0]        countdown_digit,
  output logic              song_done
);

  state_t            state_q;
  state_t            state_d;
  logic              enter_cd;
  logic              sec_tick;
  logic [TIME_W-1:0] len_q;

  assign state = state_q;

  // The prescaler restarts on every countdown entry so each countdown lasts whole seconds.
  cl_sec_prescaler #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (enter_cd),
    .en       (state_q == ST_COUNTDOWN),
    .sec_tick (sec_tick)
  );

  // Next state: abort beats start beats pause; abort in IDLE still consumes the cycle.
  always_comb begin
    state_d  = state_q;
    enter_cd = 1'b0;
    if (abort_p) begin
      if (state_q != ST_IDLE) state_d = ST_IDLE;
    end else if (start_p) begin
      state_d  = ST_COUNTDOWN;
      enter_cd = 1'b1;
    end else begin
      case (state_q)
        ST_COUNTDOWN: begin
          if (sec_tick && countdown_digit == 4'd1)
            state_d = (len_q == '0) ? ST_FINISHED : ST_PLAYING;
        end
        ST_PLAYING: begin
          if (pause_p)                 state_d = ST_PAUSED;
          else if (song_time >= len_q) state_d = ST_FINISHED;
        end
        ST_PAUSED: begin
          if (pause_p) state_d = ST_PLAYING;
        end
        default: ;
      endcase
    end
  end

  // State and all outputs are registered from the next-state decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      timer_pause     <= 1'b1;
      timer_reset     <= 1'b1;
      countdown_digit <= 4'd0;
      song_done       <= 1'b0;
      len_q           <= '0;
    end else begin
      state_q     <= state_d;
      timer_pause <= (state_d != ST_PLAYING);
      timer_reset <= enter_cd || (state_d == ST_IDLE && state_q != ST_IDLE);
      song_done   <= (state_d == ST_FINISHED) && (state_q != ST_FINISHED);
      if (enter_cd) len_q <= song_length;
      if (state_d != ST_COUNTDOWN)  countdown_digit <= 4'd0;
      else if (enter_cd)            countdown_digit <= 4'(COUNTDOWN_SEC);
      else if (sec_tick)            countdown_digit <= countdown_digit - 4'd1;
    end
  end

endmodule

// File: tb/tb_cl_song_sequencer.sv
// Bench for cl_song_sequencer: directed scenarios plus random requests against a behavioural model.
// Latency: model predicts outputs one cycle after each sampled input set.
// Backpressure: n/a.
module tb_cl_song_sequencer;

  localparam int CPS = 10;
  localparam int CD  = 3;
  localparam int TW  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_p = 1'b0;
  logic          pause_p = 1'b0;
  logic          abort_p = 1'b0;
  logic [TW-1:0] song_length = '0;
  logic [TW-1:0] song_time = '0;
  logic          timer_pause;
  logic          timer_reset;
  logic [2:0]    state;
  logic [3:0]    countdown_digit;
  logic          song_done;

  cl_song_sequencer #(
    .CYCLES_PER_SEC(CPS),
    .COUNTDOWN_SEC (CD),
    .TIME_W        (TW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_p        (start_p),
    .pause_p        (pause_p),
    .abort_p        (abort_p),
    .song_length    (song_length),
    .song_time      (song_time),
    .timer_pause    (timer_pause),
    .timer_reset    (timer_reset),
    .state          (state),
    .countdown_digit(countdown_digit),
    .song_done      (song_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: game state code, latched length, cycles spent in the current countdown.
  int ms = 0;
  int mlen = 0;
  int melapsed = 0;
  int e_state = 0, e_pause = 1, e_reset = 1, e_digit = 0, e_done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step(input bit st, input bit pa, input bit ab, input bit rs,
                            input int len, input int tm);
    int prev;
    bit entered;
    prev    = ms;
    entered = 1'b0;
    if (rs) begin
      ms = 0; mlen = 0; melapsed = 0;
      e_state = 0; e_pause = 1; e_reset = 1; e_digit = 0; e_done = 0;
      return;
    end
    if (ab) begin
      if (ms != 0) ms = 0;
    end else if (st) begin
      ms = 1; mlen = len; melapsed = 0; entered = 1'b1;
    end else begin
      if (ms == 1) begin
        melapsed++;
        if (melapsed == CD * CPS) ms = (mlen == 0) ? 4 : 2;
      end else if (ms == 2) begin
        if (pa) ms = 3;
        else if (tm >= mlen) ms = 4;
      end else if (ms == 3) begin
        if (pa) ms = 2;
      end
    end
    e_state = ms;
    e_pause = (ms != 2);
    e_reset = entered || (ms == 0 && prev != 0);
    e_done  = (ms == 4 && prev != 4);
    e_digit = (ms == 1) ? CD - melapsed / CPS : 0;
  endtask

  // Drive one cycle of inputs, advance the model, then compare all outputs away from the edge.
  task automatic step(input bit st, input bit pa, input bit ab, input bit rs,
                      input int len, input int tm);
    start_p     = st;
    pause_p     = pa;
    abort_p     = ab;
    reset       = rs;
    song_length = TW'(len);
    song_time   = TW'(tm);
    model_step(st, pa, ab, rs, len, tm);
    @(negedge clk);
    chk("state",       int'(state),           e_state);
    chk("timer_pause", int'(timer_pause),     e_pause);
    chk("timer_reset", int'(timer_reset),     e_reset);
    chk("digit",       int'(countdown_digit), e_digit);
    chk("song_done",   int'(song_done),       e_done);
  endtask

  task automatic idle(input int tm);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, tm);
  endtask

  initial begin
    bit st, pa, ab, rs;
    int len, tm;
    bit saw_playing;

    @(negedge clk);

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("lit_rst_state", int'(state), 0);
    chk("lit_rst_pause", int'(timer_pause), 1);
    chk("lit_rst_treset", int'(timer_reset), 1);
    chk("lit_rst_digit", int'(countdown_digit), 0);
    idle(0);
    chk("lit_rst_treset_drop", int'(timer_reset), 0);

    // Start with length 5: countdown 3-2-1 then PLAYING 30 cycles later
    step(1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    chk("lit_cd_state", int'(state), 1);
    chk("lit_cd_treset", int'(timer_reset), 1);
    chk("lit_cd_digit3", int'(countdown_digit), 3);
    repeat (9) idle(0);
    chk("lit_cd_digit3_end", int'(countdown_digit), 3);
    idle(0);
    chk("lit_cd_digit2", int'(countdown_digit), 2);
    repeat (10) idle(0);
    chk("lit_cd_digit1", int'(countdown_digit), 1);
    repeat (9) idle(0);
    chk("lit_cd_still", int'(state), 1);
    idle(0);
    chk("lit_play_state", int'(state), 2);
    chk("lit_play_pause", int'(timer_pause), 0);

    // End detection at song_time == length
    idle(4);
    chk("lit_t4_playing", int'(state), 2);
    idle(5);
    chk("lit_fin_state", int'(state), 4);
    chk("lit_fin_done", int'(song_done), 1);
    chk("lit_fin_pause", int'(timer_pause), 1);
    idle(5);
    chk("lit_fin_done_drop", int'(song_done), 0);

    // Pause / resume, no end detection while paused
    step(1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    repeat (30) idle(0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("lit_paused", int'(state), 3);
    chk("lit_paused_tp", int'(timer_pause), 1);
    idle(9);
    chk("lit_paused_hold", int'(state), 3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 9);
    chk("lit_resumed", int'(state), 2);
    idle(9);
    chk("lit_resume_fin", int'(state), 4);

    // Simultaneous abort+start+pause, then zero-length song
    step(1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    repeat (30) idle(0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5, 0);
    chk("lit_abort_state", int'(state), 0);
    chk("lit_abort_treset", int'(timer_reset), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    saw_playing = 1'b0;
    repeat (29) begin
      idle(0);
      if (state == 3'd2) saw_playing = 1'b1;
    end
    idle(0);
    chk("lit_zero_fin", int'(state), 4);
    chk("lit_zero_done", int'(song_done), 1);
    chk("lit_zero_noplay", int'(saw_playing), 0);

    // Reset in mid-countdown
    step(1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    repeat (10) idle(0);
    chk("lit_mid_digit2", int'(countdown_digit), 2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("lit_mid_rst_state", int'(state), 0);
    chk("lit_mid_rst_digit", int'(countdown_digit), 0);
    repeat (40) idle(0);
    chk("lit_mid_no_play", int'(state), 0);

    // Random requests checked against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 39) == 0);
      pa  = ($urandom_range(0, 7) == 0);
      ab  = (ms != 0) && ($urandom_range(0, 59) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      len = $urandom_range(0, 10);
      tm  = $urandom_range(0, 12);
      if (ms == 2 && tm >= mlen) pa = 1'b0;
      step(st, pa, ab, rs, len, tm);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
